// File: rtl/rx_cmd_decoder.sv
// Pops header[+msb+lsb] command frames from the rx FIFO and presents each one as a
// single command word on a valid/ready handshake. Optional trailing XOR checksum: RX_CMD_CHECKSUM_EN.
module rx_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES   = 100000,
  parameter int unsigned PAYLOAD_FLAG_BIT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_rdata,
  input  logic        rx_rempty,
  output logic        rx_rinc,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic [15:0] cmd_data,
  output logic        err_timeout,
  output logic        err_checksum,
  output logic        busy,
  output logic [15:0] frame_count
);

`ifdef RX_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, GET_MSB, GET_LSB, GET_CHK, OUT} state_t;
  localparam state_t AFTER_DATA = GET_CHK;
`else
  typedef enum logic [2:0] {IDLE, GET_MSB, GET_LSB, OUT} state_t;
  localparam state_t AFTER_DATA = OUT;
`endif

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [31:0] wait_cnt, wait_cnt_next;
  logic [7:0]  code_next;
  logic [15:0] data_next;
  logic [15:0] count_next;
  logic        pop;
  logic        in_fetch;
  logic        timeout_hit;
`ifdef RX_CMD_CHECKSUM_EN
  logic        chk_err;
`endif

  // The timeout fires on the TIMEOUT_CYCLES-th consecutive empty cycle, so it can never
  // coincide with a byte being available; that byte is simply left for the next header.
  always_comb begin
    in_fetch = (state == GET_MSB) || (state == GET_LSB);
`ifdef RX_CMD_CHECKSUM_EN
    in_fetch = in_fetch || (state == GET_CHK);
`endif
    timeout_hit = in_fetch && rx_rempty && (TIMEOUT_CYCLES != 0) &&
                  (wait_cnt == TIMEOUT_LIMIT - 32'd1);
    pop = (state != OUT) && !rx_rempty && !rst && !timeout_hit;
  end

  assign rx_rinc   = pop;
  assign cmd_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next  = state;
    code_next   = cmd_code;
    data_next   = cmd_data;
    count_next  = frame_count;
    err_timeout = 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
    chk_err     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pop) begin
          code_next = rx_rdata;
          if (rx_rdata[PAYLOAD_FLAG_BIT]) begin
            state_next = GET_MSB;
          end else begin
            data_next  = 16'h0000;
            state_next = AFTER_DATA;
          end
        end
      end
      GET_MSB: begin
        if (timeout_hit) begin
          err_timeout = 1'b1;
          state_next  = IDLE;
        end else if (pop) begin
          data_next[15:8] = rx_rdata;
          state_next      = GET_LSB;
        end
      end
      GET_LSB: begin
        if (timeout_hit) begin
          err_timeout = 1'b1;
          state_next  = IDLE;
        end else if (pop) begin
          data_next[7:0] = rx_rdata;
          state_next     = AFTER_DATA;
        end
      end
`ifdef RX_CMD_CHECKSUM_EN
      // cmd_data is zero for header-only frames, so one XOR covers both frame shapes.
      GET_CHK: begin
        if (timeout_hit) begin
          err_timeout = 1'b1;
          state_next  = IDLE;
        end else if (pop) begin
          if (rx_rdata == (cmd_code ^ cmd_data[15:8] ^ cmd_data[7:0])) begin
            state_next = OUT;
          end else begin
            chk_err    = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      OUT: begin
        if (cmd_ready) begin
          count_next = frame_count + 16'd1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (in_fetch && rx_rempty && (state_next == state)) begin
      wait_cnt_next = wait_cnt + 32'd1;
    end else begin
      wait_cnt_next = 32'd0;
    end
  end

`ifdef RX_CMD_CHECKSUM_EN
  assign err_checksum = chk_err;
`else
  assign err_checksum = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_code    <= 8'h00;
      cmd_data    <= 16'h0000;
      frame_count <= 16'h0000;
      wait_cnt    <= 32'd0;
    end else begin
      state       <= state_next;
      cmd_code    <= code_next;
      cmd_data    <= data_next;
      frame_count <= count_next;
      wait_cnt    <= wait_cnt_next;
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Scoreboard bench for rx_cmd_decoder: stimulus queues FIFO bytes and expected events,
// a separate monitor pops and compares on each handshake or error pulse.
`timescale 1ns/1ps
module tb_rx_cmd_decoder;
  localparam int TO = 16;
`ifdef RX_CMD_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef enum int {EV_CMD = 0, EV_TIMEOUT = 1, EV_CHKERR = 2} ev_t;
  typedef struct {
    ev_t         kind;
    logic [7:0]  code;
    logic [15:0] data;
    logic [15:0] count;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_rdata;
  logic        rx_rempty;
  logic        rx_rinc;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [15:0] cmd_data;
  logic        err_timeout;
  logic        err_checksum;
  logic        busy;
  logic [15:0] frame_count;

  exp_t        sb[$];
  logic [7:0]  fifo_q[$];
  int          cyc;
  int          checks;
  int          failures;
  logic [15:0] exp_count;
  logic        last_pop;

  always #5 clk = ~clk;

  rx_cmd_decoder #(.TIMEOUT_CYCLES(TO), .PAYLOAD_FLAG_BIT(7)) dut (
    .clk(clk), .rst(rst), .rx_rdata(rx_rdata), .rx_rempty(rx_rempty), .rx_rinc(rx_rinc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_data(cmd_data),
    .err_timeout(err_timeout), .err_checksum(err_checksum), .busy(busy),
    .frame_count(frame_count)
  );

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // First-word-fall-through FIFO model: head byte is always visible when not empty.
  function automatic void driveFifo();
    rx_rempty = (fifo_q.size() == 0);
    rx_rdata  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  function automatic void pushByte(logic [7:0] b);
    fifo_q.push_back(b);
    driveFifo();
  endfunction

  task automatic tick();
    @(negedge clk);
    last_pop = rx_rinc;
    @(posedge clk);
    #1;
    if (last_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    cyc++;
    driveFifo();
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Queues one frame (plus checksum byte when enabled); the command is expected
  // lat+delay cycles after the header pop, assuming the header is popped this cycle.
  task automatic applyStimulus(input logic [7:0] hdr, input logic [15:0] data,
                               input int delay, input bit ok);
    exp_t e;
    int lat;
    logic [7:0] chk;
    pushByte(hdr);
    chk = hdr;
    lat = 1 + CK;
    if (hdr[7]) begin
      pushByte(data[15:8]);
      pushByte(data[7:0]);
      chk = chk ^ data[15:8] ^ data[7:0];
      lat += 2;
    end
`ifdef RX_CMD_CHECKSUM_EN
    pushByte(chk);
`endif
    if (ok) begin
      e.kind  = EV_CMD;
      e.code  = hdr;
      e.data  = hdr[7] ? data : 16'h0000;
      e.count = exp_count;
      e.due   = cyc + lat + delay;
      sb.push_back(e);
      exp_count++;
    end
  endtask

  task automatic expectError(input ev_t kind, input int due);
    exp_t e;
    e.kind  = kind;
    e.code  = 8'h00;
    e.data  = 16'h0000;
    e.count = 16'h0000;
    e.due   = due;
    sb.push_back(e);
  endtask

  // Monitor: every accepted command or error pulse must match the next expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && ((cmd_valid && cmd_ready) || err_timeout || err_checksum)) begin
        ev_t got;
        exp_t e;
        got = (cmd_valid && cmd_ready) ? EV_CMD : (err_timeout ? EV_TIMEOUT : EV_CHKERR);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, required none", got, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("event_kind", 32'(got), 32'(e.kind));
          checkOutput("event_cycle", 32'(cyc), 32'(e.due));
          if (e.kind == EV_CMD) begin
            checkOutput("cmd_code", 32'(cmd_code), 32'(e.code));
            checkOutput("cmd_data", 32'(cmd_data), 32'(e.data));
            checkOutput("frame_count_at_accept", 32'(frame_count), 32'(e.count));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int c;
    rst = 1'b1;
    cmd_ready = 1'b0;
    cyc = 0;
    checks = 0;
    failures = 0;
    exp_count = 16'h0000;
    last_pop = 1'b0;
    driveFifo();

    // Reset with a byte waiting: nothing may be popped and every output is zero.
    pushByte(8'h01);
    #2;
    checkOutput("reset_rinc", 32'(rx_rinc), 32'd0);
    checkOutput("reset_valid", 32'(cmd_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_code", 32'(cmd_code), 32'd0);
    checkOutput("reset_data", 32'(cmd_data), 32'd0);
    checkOutput("reset_count", 32'(frame_count), 32'd0);
    checkOutput("reset_errs", 32'({err_timeout, err_checksum}), 32'd0);
    tickN(2);
    fifo_q.delete();
    driveFifo();
    rst = 1'b0;
    cmd_ready = 1'b1;
    tick();

    // Header-only frame: valid one cycle after the pop.
    applyStimulus(8'h01, 16'h0000, 0, 1);
    tickN(4);
    checkOutput("count_after_first", 32'(frame_count), 32'd1);

    // Payload frame back to back: three consecutive pops, valid on cycle 3.
    applyStimulus(8'h83, 16'hA55A, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("burst_pop_%0d", i), 32'(last_pop), 32'd1);
    end
    tickN(3 + CK);
    checkOutput("count_after_second", 32'(frame_count), 32'd2);

    // Backpressure: 20 cycles of cmd_ready=0 with a second frame queued behind.
    cmd_ready = 1'b0;
    applyStimulus(8'h81, 16'h1122, 20, 1);
    applyStimulus(8'h05, 16'h0000, 24 + CK, 1);
    tickN(3 + CK);
    checkOutput("stall_valid", 32'(cmd_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rx_rinc !== 1'b0 || cmd_valid !== 1'b1 || cmd_code !== 8'h81 || cmd_data !== 16'h1122)
        bad++;
      tick();
    end
    checkOutput("stall_stable", 32'(bad), 32'd0);
    cmd_ready = 1'b1;
    tickN(5 + CK);
    checkOutput("count_after_stall", 32'(frame_count), 32'd4);

    // Starve after header+msb: timeout on the 16th empty cycle, frame dropped.
    c = cyc;
    pushByte(8'h83);
    pushByte(8'h12);
    expectError(EV_TIMEOUT, c + 1 + TO);
    tickN(TO + 2);
    checkOutput("timeout_idle", 32'(busy), 32'd0);
    checkOutput("timeout_count", 32'(frame_count), 32'd4);
    applyStimulus(8'h02, 16'h0000, 0, 1);
    tickN(3 + CK);
    checkOutput("count_after_timeout", 32'(frame_count), 32'd5);

`ifdef RX_CMD_CHECKSUM_EN
    // Correct XOR trailer accepted; zero trailer rejected without cmd_valid.
    c = cyc;
    pushByte(8'h83); pushByte(8'h12); pushByte(8'h34); pushByte(8'hA5);
    begin
      exp_t e;
      e.kind = EV_CMD; e.code = 8'h83; e.data = 16'h1234; e.count = exp_count; e.due = c + 4;
      sb.push_back(e);
      exp_count++;
    end
    tickN(6);
    c = cyc;
    pushByte(8'h83); pushByte(8'h12); pushByte(8'h34); pushByte(8'h00);
    expectError(EV_CHKERR, c + 3);
    tickN(6);
    checkOutput("count_after_chk", 32'(frame_count), 32'd6);
`endif

    // Reset while waiting for the lsb: outputs clear at once, nothing pops.
    pushByte(8'h83);
    pushByte(8'hAB);
    tickN(2);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    pushByte(8'h44);
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_outputs", 32'({cmd_valid, cmd_code, cmd_data}), 32'd0);
    checkOutput("midreset_count", 32'(frame_count), 32'd0);
    checkOutput("midreset_rinc", 32'(rx_rinc), 32'd0);
    tick();
    fifo_q.delete();
    driveFifo();
    rst = 1'b0;
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    exp_count = 16'hFFFF;
    checkOutput("preload", 32'(frame_count), 32'h0000FFFF);
    applyStimulus(8'h87, 16'hBEEF, 0, 1);
    tickN(5 + CK);
    checkOutput("count_wrap", 32'(frame_count), 32'd0);

    tickN(5);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
